// File: rtl/ysyx_22040386_mem_arbiter_pkg.sv
// Shared encodings for the IFU/MEMU memory-port arbiter.
package ysyx_22040386_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/ysyx_22040386_arb_streak.sv
// Saturating count of back-to-back data grants taken while a fetch was waiting.
module ysyx_22040386_arb_streak
  import ysyx_22040386_mem_arbiter_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STREAK_W-1:0] MAX_C = STREAK_W'(MAX);

  logic [STREAK_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != MAX_C) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX_C);

endmodule

// File: rtl/ysyx_22040386_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Data wins ties unless fetch has been passed over STREAK_MAX times in a row.
module ysyx_22040386_mem_arbiter
  import ysyx_22040386_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STREAK_MAX = 4
) (
  input  logic                i_ARB_clk,
  input  logic                i_ARB_rst,
  input  logic                i_ARB_if_req,
  input  logic [ADDR_W-1:0]   i_ARB_if_addr,
  output logic                o_ARB_if_gnt,
  output logic                o_ARB_if_rvalid,
  output logic [DATA_W-1:0]   o_ARB_if_rdata,
  input  logic                i_ARB_d_req,
  input  logic                i_ARB_d_we,
  input  logic [ADDR_W-1:0]   i_ARB_d_addr,
  input  logic [DATA_W-1:0]   i_ARB_d_wdata,
  input  logic [DATA_W/8-1:0] i_ARB_d_wmask,
  output logic                o_ARB_d_gnt,
  output logic                o_ARB_d_rvalid,
  output logic [DATA_W-1:0]   o_ARB_d_rdata,
  output logic                o_ARB_m_valid,
  output logic                o_ARB_m_we,
  output logic [ADDR_W-1:0]   o_ARB_m_addr,
  output logic [DATA_W-1:0]   o_ARB_m_wdata,
  output logic [DATA_W/8-1:0] o_ARB_m_wmask,
  input  logic                i_ARB_m_ready,
  input  logic                i_ARB_m_rvalid,
  input  logic [DATA_W-1:0]   i_ARB_m_rdata
);

  arb_state_e          state, state_nxt;
  arb_owner_e          owner;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                grant_if, grant_d;
  logic                streak_at_max;
  logic                resp;

  always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
    if (i_ARB_rst) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Fetch only beats a pending data request once the streak is exhausted.
        if (i_ARB_d_req && !(i_ARB_if_req && streak_at_max)) begin
          grant_d   = 1'b1;
          state_nxt = ST_REQ;
        end else if (i_ARB_if_req) begin
          grant_if  = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ:  if (i_ARB_m_ready)  state_nxt = ST_WAIT;
      ST_WAIT: if (i_ARB_m_rvalid) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
    if (i_ARB_rst) begin
      owner   <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (grant_d) begin
      owner   <= OWN_D;
      we_q    <= i_ARB_d_we;
      addr_q  <= i_ARB_d_addr;
      wdata_q <= i_ARB_d_wdata;
      wmask_q <= i_ARB_d_wmask;
    end else if (grant_if) begin
      owner   <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= i_ARB_if_addr;
      wdata_q <= '0;
      wmask_q <= '0;
    end
  end

  ysyx_22040386_arb_streak #(
    .MAX (STREAK_MAX)
  ) u_streak (
    .clk    (i_ARB_clk),
    .rst    (i_ARB_rst),
    .inc    (grant_d & i_ARB_if_req),
    .clr    (grant_if | (grant_d & ~i_ARB_if_req)),
    .at_max (streak_at_max)
  );

  assign o_ARB_if_gnt  = grant_if;
  assign o_ARB_d_gnt   = grant_d;
  assign o_ARB_m_valid = (state == ST_REQ);
  assign o_ARB_m_we    = we_q;
  assign o_ARB_m_addr  = addr_q;
  assign o_ARB_m_wdata = wdata_q;
  assign o_ARB_m_wmask = wmask_q;

  // Responses only count in WAIT; read data is zeroed for the side that does not own the bus.
  assign resp            = (state == ST_WAIT) && i_ARB_m_rvalid;
  assign o_ARB_if_rvalid = resp && (owner == OWN_IF);
  assign o_ARB_d_rvalid  = resp && (owner == OWN_D);
  assign o_ARB_if_rdata  = (state == ST_WAIT && owner == OWN_IF) ? i_ARB_m_rdata : '0;
  assign o_ARB_d_rdata   = (state == ST_WAIT && owner == OWN_D)  ? i_ARB_m_rdata : '0;

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// Directed bench for the memory arbiter: one task per scenario, inline checks.
module tb_ysyx_22040386_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic [7:0]  d_wmask;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;
  logic        m_valid, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  logic        m_ready, m_rvalid;
  logic [63:0] m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22040386_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STREAK_MAX(4)) dut (
    .i_ARB_clk       (clk),
    .i_ARB_rst       (rst),
    .i_ARB_if_req    (if_req),
    .i_ARB_if_addr   (if_addr),
    .o_ARB_if_gnt    (if_gnt),
    .o_ARB_if_rvalid (if_rvalid),
    .o_ARB_if_rdata  (if_rdata),
    .i_ARB_d_req     (d_req),
    .i_ARB_d_we      (d_we),
    .i_ARB_d_addr    (d_addr),
    .i_ARB_d_wdata   (d_wdata),
    .i_ARB_d_wmask   (d_wmask),
    .o_ARB_d_gnt     (d_gnt),
    .o_ARB_d_rvalid  (d_rvalid),
    .o_ARB_d_rdata   (d_rdata),
    .o_ARB_m_valid   (m_valid),
    .o_ARB_m_we      (m_we),
    .o_ARB_m_addr    (m_addr),
    .o_ARB_m_wdata   (m_wdata),
    .o_ARB_m_wmask   (m_wmask),
    .i_ARB_m_ready   (m_ready),
    .i_ARB_m_rvalid  (m_rvalid),
    .i_ARB_m_rdata   (m_rdata)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    m_ready = 0; m_rvalid = 0; m_rdata = '0;
    settle();
    n_cmp++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, m_valid, m_we} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, m_valid, m_we}); end
    n_cmp++; if ({m_addr, m_wdata, m_wmask} !== 136'b0) begin n_bad++; $display("FAIL reset_fields: got %h/%h/%h want 0", m_addr, m_wdata, m_wmask); end
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_lone_fetch();
    tick();
    if_req = 1; if_addr = 64'h8000_0000;
    settle();
    n_cmp++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_bad++; $display("FAIL fetch_gnt_T0: got if=%b d=%b want if=1 d=0", if_gnt, d_gnt); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_mvalid_T0: got %b want 0", m_valid); end
    tick();
    if_req = 0; if_addr = 64'h0; m_ready = 1;
    settle();
    n_cmp++; if (m_valid !== 1'b1 || m_addr !== 64'h8000_0000 || m_we !== 1'b0 || m_wmask !== 8'h00) begin n_bad++; $display("FAIL fetch_req_T1: got v=%b a=%h we=%b m=%h want v=1 a=80000000 we=0 m=00", m_valid, m_addr, m_we, m_wmask); end
    n_cmp++; if (if_gnt !== 1'b0) begin n_bad++; $display("FAIL fetch_gnt_T1: got %b want 0", if_gnt); end
    tick();
    m_ready = 0; m_rvalid = 1; m_rdata = 64'h0013;
    settle();
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 64'h0013) begin n_bad++; $display("FAIL fetch_resp_T2: got rv=%b rd=%h want rv=1 rd=13", if_rvalid, if_rdata); end
    n_cmp++; if (d_rvalid !== 1'b0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_other_T2: got drv=%b mv=%b want 0 0", d_rvalid, m_valid); end
    tick();
    m_rvalid = 0; m_rdata = '0;
    settle();
    n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("FAIL fetch_rvalid_pulse: got %b want 0", if_rvalid); end
  endtask

  task automatic test_data_priority();
    tick();
    if_req = 1; if_addr = 64'h8000_0004;
    d_req = 1; d_we = 0; d_addr = 64'h8000_1000;
    settle();
    n_cmp++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_bad++; $display("FAIL prio_first: got d=%b if=%b want d=1 if=0", d_gnt, if_gnt); end
    tick();
    d_req = 0; d_addr = '0; m_ready = 1;
    settle();
    n_cmp++; if (m_valid !== 1'b1 || m_addr !== 64'h8000_1000 || m_we !== 1'b0) begin n_bad++; $display("FAIL prio_load_req: got v=%b a=%h we=%b want v=1 a=80001000 we=0", m_valid, m_addr, m_we); end
    tick();
    m_ready = 0; m_rvalid = 1; m_rdata = 64'h1234_5678_9abc_def0;
    settle();
    n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h1234_5678_9abc_def0 || if_rvalid !== 1'b0) begin n_bad++; $display("FAIL prio_load_resp: got drv=%b rd=%h ifrv=%b want 1 123456789abcdef0 0", d_rvalid, d_rdata, if_rvalid); end
    n_cmp++; if (if_gnt !== 1'b0) begin n_bad++; $display("FAIL prio_no_gnt_in_wait: got %b want 0", if_gnt); end
    tick();
    m_rvalid = 0;
    settle();
    n_cmp++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_bad++; $display("FAIL prio_if_next: got if=%b d=%b want if=1 d=0", if_gnt, d_gnt); end
    tick();
    if_req = 0; m_ready = 1;
    settle();
    n_cmp++; if (m_addr !== 64'h8000_0004) begin n_bad++; $display("FAIL prio_if_addr: got %h want 80000004", m_addr); end
    tick();
    m_ready = 0; m_rvalid = 1; m_rdata = 64'h0000_0093;
    settle();
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 64'h93) begin n_bad++; $display("FAIL prio_if_resp: got rv=%b rd=%h want 1 93", if_rvalid, if_rdata); end
    tick();
    m_rvalid = 0;
    settle();
  endtask

  task automatic test_streak();
    logic exp_d;
    tick();
    if_req = 1; if_addr = 64'h8000_0100;
    d_req = 1; d_we = 0; d_addr = 64'h8000_2000;
    for (int g = 0; g < 5; g++) begin
      settle();
      exp_d = (g < 4);
      n_cmp++; if (d_gnt !== exp_d || if_gnt !== !exp_d) begin n_bad++; $display("FAIL streak_grant%0d: got d=%b if=%b want d=%b if=%b", g, d_gnt, if_gnt, exp_d, !exp_d); end
      tick();
      if (!exp_d) if_req = 0;
      m_ready = 1;
      tick();
      m_ready = 0; m_rvalid = 1; m_rdata = 64'(g);
      settle();
      n_cmp++; if (d_rvalid !== exp_d || if_rvalid !== !exp_d) begin n_bad++; $display("FAIL streak_resp%0d: got d=%b if=%b want d=%b if=%b", g, d_rvalid, if_rvalid, exp_d, !exp_d); end
      tick();
      m_rvalid = 0;
      if (g == 4) d_req = 0;
    end
    // Streak cleared by the fetch grant: data must win the next four contested grants again.
    if_req = 1; d_req = 1;
    settle();
    n_cmp++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_bad++; $display("FAIL streak_cleared: got d=%b if=%b want d=1 if=0", d_gnt, if_gnt); end
    tick();
    if_req = 0; d_req = 0; m_ready = 1;
    tick();
    m_ready = 0; m_rvalid = 1;
    tick();
    m_rvalid = 0;
    settle();
  endtask

  task automatic test_store();
    int d_seen;
    int if_seen;
    d_seen = 0; if_seen = 0;
    tick();
    d_req = 1; d_we = 1; d_addr = 64'h8000_3008; d_wdata = 64'hDEAD_BEEF; d_wmask = 8'h0F;
    settle();
    n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL store_gnt: got %b want 1", d_gnt); end
    tick();
    d_req = 0; d_we = 0; d_addr = 64'h1; d_wdata = 64'h5555; d_wmask = 8'hF0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) m_ready = 1;
      settle();
      n_cmp++; if (m_valid !== 1'b1 || m_we !== 1'b1 || m_addr !== 64'h8000_3008 || m_wdata !== 64'hDEAD_BEEF || m_wmask !== 8'h0F) begin n_bad++; $display("FAIL store_stable%0d: got v=%b we=%b a=%h d=%h m=%h want 1 1 80003008 deadbeef 0f", c, m_valid, m_we, m_addr, m_wdata, m_wmask); end
      tick();
    end
    m_ready = 0; m_rvalid = 1; m_rdata = 64'hFFFF;
    for (int c = 0; c < 3; c++) begin
      settle();
      if (d_rvalid === 1'b1) d_seen++;
      if (if_rvalid === 1'b1) if_seen++;
      tick();
      m_rvalid = 0;
    end
    n_cmp++; if (d_seen !== 1) begin n_bad++; $display("FAIL store_d_rvalid_count: got %0d want 1", d_seen); end
    n_cmp++; if (if_seen !== 0) begin n_bad++; $display("FAIL store_if_rvalid_count: got %0d want 0", if_seen); end
  endtask

  task automatic test_reset_in_wait();
    tick();
    if_req = 1; if_addr = 64'h8000_0200;
    tick();
    if_req = 0; m_ready = 1;
    tick();
    m_ready = 0;
    settle();
    rst = 1;
    #1;
    n_cmp++; if ({m_valid, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 5'b0 || m_addr !== 64'h0) begin n_bad++; $display("FAIL rst_wait_outputs: got v=%b g=%b%b rv=%b%b a=%h want all 0", m_valid, if_gnt, d_gnt, if_rvalid, d_rvalid, m_addr); end
    tick();
    rst = 0; m_rvalid = 1; m_rdata = 64'hBAD;
    settle();
    n_cmp++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 64'h0) begin n_bad++; $display("FAIL rst_late_rvalid: got if=%b d=%b rd=%h want 0 0 0", if_rvalid, d_rvalid, if_rdata); end
    tick();
    m_rvalid = 0;
    if_req = 1; if_addr = 64'h8000_0300;
    settle();
    n_cmp++; if (if_gnt !== 1'b1) begin n_bad++; $display("FAIL rst_fresh_gnt: got %b want 1", if_gnt); end
    tick();
    if_req = 0; m_ready = 1;
    settle();
    n_cmp++; if (m_valid !== 1'b1 || m_addr !== 64'h8000_0300) begin n_bad++; $display("FAIL rst_fresh_req: got v=%b a=%h want 1 80000300", m_valid, m_addr); end
    tick();
    m_ready = 0; m_rvalid = 1; m_rdata = 64'h0517;
    settle();
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 64'h0517) begin n_bad++; $display("FAIL rst_fresh_resp: got rv=%b rd=%h want 1 517", if_rvalid, if_rdata); end
    tick();
    m_rvalid = 0;
    settle();
  endtask

  task automatic test_spurious_rvalid();
    tick();
    m_rvalid = 1; m_rdata = 64'h77;
    settle();
    n_cmp++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL spur_idle: got if=%b d=%b v=%b want 0 0 0", if_rvalid, d_rvalid, m_valid); end
    tick();
    m_rvalid = 0;
    settle();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL spur_idle_state: got v=%b want 0", m_valid); end
    tick();
    d_req = 1; d_we = 0; d_addr = 64'h8000_4000;
    tick();
    d_req = 0; m_rvalid = 1;
    settle();
    n_cmp++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || m_valid !== 1'b1) begin n_bad++; $display("FAIL spur_req: got d=%b if=%b v=%b want 0 0 1", d_rvalid, if_rvalid, m_valid); end
    tick();
    m_rvalid = 0;
    settle();
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL spur_req_state: got v=%b want 1", m_valid); end
    tick();
    m_ready = 1;
    tick();
    m_ready = 0; m_rvalid = 1; m_rdata = 64'hCAFE;
    settle();
    n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 64'hCAFE) begin n_bad++; $display("FAIL spur_then_resp: got rv=%b rd=%h want 1 cafe", d_rvalid, d_rdata); end
    tick();
    m_rvalid = 0;
    settle();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_data_priority();
    test_streak();
    test_store();
    test_reset_in_wait();
    test_spurious_rvalid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
